// File: rtl/alu_req_scheduler_pkg.sv
// rtl/alu_req_scheduler_pkg.sv - shared types and constants for the ALU request scheduler
package alu_sched_pkg;

    localparam int OP_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - small signed ALU, N+1-bit operands widened to an N+3-bit result
module alu
    import alu_sched_pkg::*;
#(
    parameter int n = 3
) (
    input  logic signed [n:0]      i_x,
    input  logic signed [n:0]      i_y,
    input  logic [OP_W-1:0]        i_s,
    output logic signed [n+2:0]    o_alu
);

    logic signed [n+2:0] w_xe;
    logic signed [n+2:0] w_ye;

    assign w_xe = {{2{i_x[n]}}, i_x};
    assign w_ye = {{2{i_y[n]}}, i_y};

    // Operate on sign-extended operands so every code fits the result without overflow
    always_comb begin
        o_alu = '0;
        case (i_s)
            3'd0:    o_alu = w_xe + w_ye;
            3'd1:    o_alu = w_xe - w_ye;
            3'd2:    o_alu = w_xe & w_ye;
            3'd3:    o_alu = w_xe | w_ye;
            3'd4:    o_alu = w_xe ^ w_ye;
            3'd5:    o_alu = -w_xe;
            3'd6:    o_alu = w_xe >>> 1;
            default: o_alu = w_xe <<< 2;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant, purely combinational
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    input  logic       en,
    output logic [1:0] grant
);

    // A lone requester always wins; on a tie the priority pointer picks
    always_comb begin
        grant    = 2'b00;
        grant[0] = en & valid[0] & (~valid[1] | ~prio);
        grant[1] = en & valid[1] & (~valid[0] | prio);
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// rtl/alu_req_scheduler.sv - shares one ALU between two requesters with a registered response
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int N     = 3,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic signed [N:0]       req0_x,
    input  logic signed [N:0]       req0_y,
    input  logic [OP_W-1:0]         req0_s,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic signed [N:0]       req1_x,
    input  logic signed [N:0]       req1_y,
    input  logic [OP_W-1:0]         req1_s,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic signed [N+2:0]     rsp_o,
    output logic                    busy,
    output logic [CNT_W-1:0]        op_count
);

    state_t                 r_state;
    logic                   r_prio;
    logic                   r_id;
    logic signed [N:0]      r_x;
    logic signed [N:0]      r_y;
    logic [OP_W-1:0]        r_s;
    logic                   r_rsp_valid;
    logic                   r_rsp_id;
    logic signed [N+2:0]    r_rsp_o;
    logic [CNT_W-1:0]       r_op_count;

    logic [1:0]             w_grant;
    logic                   w_arb_en;
    logic signed [N+2:0]    w_alu_o;

    // Grants only happen in IDLE, and never while reset is asserted
    assign w_arb_en = (r_state == IDLE) && !reset;

    rr_arb2 u_arb (
        .valid (({req1_valid, req0_valid})),
        .prio  (r_prio),
        .en    (w_arb_en),
        .grant (w_grant)
    );

    alu #(.n(N)) u_alu (
        .i_x   (r_x),
        .i_y   (r_y),
        .i_s   (r_s),
        .o_alu (w_alu_o)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_o      = r_rsp_o;
    assign op_count   = r_op_count;
    assign busy       = (r_state != IDLE);

    // Request/execute/respond sequencer; reset discards any in-flight op
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_prio      <= 1'b0;
            r_id        <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_s         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_o     <= '0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_x     <= w_grant[1] ? req1_x : req0_x;
                        r_y     <= w_grant[1] ? req1_y : req0_y;
                        r_s     <= w_grant[1] ? req1_s : req0_s;
                        r_id    <= w_grant[1];
                        r_prio  <= ~w_grant[1];
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_o     <= w_alu_o;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_op_count  <= r_op_count + CNT_W'(1);
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb/tb_alu_req_scheduler.sv - directed and sweep checks for alu_req_scheduler
module tb_alu_req_scheduler;

    localparam int N     = 3;
    localparam int CNT_W = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 req0_valid, req0_ready, req1_valid, req1_ready;
    logic signed [N:0]    req0_x, req0_y, req1_x, req1_y;
    logic [2:0]           req0_s, req1_s;
    logic                 rsp_valid, rsp_ready, rsp_id, busy;
    logic signed [N+2:0]  rsp_o;
    logic [CNT_W-1:0]     op_count;

    int checks = 0;
    int errors = 0;

    alu_req_scheduler #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_s     (req0_s),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_s     (req1_s),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_o      (rsp_o),
        .busy       (busy),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int port;
        int x;
        int y;
        int s;
        int exp_o;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic signed [N+2:0] gold(input int x, input int y, input int s);
        int r;
        case (s)
            0:       r = x + y;
            1:       r = x - y;
            2:       r = x & y;
            3:       r = x | y;
            4:       r = x ^ y;
            5:       r = -x;
            6:       r = x >>> 1;
            default: r = x * 4;
        endcase
        return r[N+2:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input bit v, input int x, input int y, input int s);
        if (port == 0) begin
            req0_valid = v; req0_x = x[N:0]; req0_y = y[N:0]; req0_s = s[2:0];
        end else begin
            req1_valid = v; req1_x = x[N:0]; req1_y = y[N:0]; req1_s = s[2:0];
        end
    endtask

    // One complete op on one port; operands are scrambled right after acceptance
    task automatic run_op(input int port, input int x, input int y, input int s, input bit rnd,
                          output int id, output int o);
        int n;
        drive(port, 1'b1, x, y, s);
        #1;
        n = 0;
        while (!((port == 0) ? req0_ready : req1_ready) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("accept_timeout", n, 0);
        tick();
        drive(port, 1'b0, x ^ 5, y ^ 3, s ^ 6);
        n = 0;
        rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!(rsp_valid && rsp_ready) && n < 60) begin
            tick();
            rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        if (n >= 60) chk("rsp_timeout", n, 0);
        id = rsp_id;
        o  = rsp_o;
        tick();
        rsp_ready = 1'b1;
    endtask

    vec_t vecs[14];
    int   id, o, nr, base, nreq, cnt0;
    int   g[$];
    int   rid[$];
    int   ro[$];

    initial begin
        vecs[0]  = '{0,  3,  5, 0,   8};
        vecs[1]  = '{1,  7,  7, 0,  14};
        vecs[2]  = '{0, -8, -8, 0, -16};
        vecs[3]  = '{1, -8,  7, 1, -15};
        vecs[4]  = '{0,  7, -8, 1,  15};
        vecs[5]  = '{1,  5,  3, 2,   1};
        vecs[6]  = '{0, -3, -6, 2,  -8};
        vecs[7]  = '{1,  5,  3, 3,   7};
        vecs[8]  = '{0,  5,  3, 4,   6};
        vecs[9]  = '{1, -8,  0, 5,   8};
        vecs[10] = '{0, -7,  0, 6,  -4};
        vecs[11] = '{1,  7,  0, 6,   3};
        vecs[12] = '{0, -1,  0, 7,  -4};
        vecs[13] = '{1,  7,  0, 7,  28};

        reset = 1'b1; rsp_ready = 1'b1;
        drive(0, 1'b1, 3, 5, 0);
        drive(1, 1'b0, 0, 0, 0);
        tick(); tick();

        // Reset state, ready suppressed while reset is high
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_o", rsp_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_req0_ready", req0_ready, 0);

        // Test 1: single op latency
        reset = 1'b0;
        #1;
        chk("t1_ready_cycle1", req0_ready, 1);
        tick();
        drive(0, 1'b0, 0, 0, 0);
        chk("t1_exec_rsp_valid", rsp_valid, 0);
        chk("t1_exec_busy", busy, 1);
        tick();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_o", rsp_o, 8);
        tick();
        chk("t1_op_count", op_count, 1);
        chk("t1_idle_busy", busy, 0);

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].port, vecs[i].x, vecs[i].y, vecs[i].s, 1'b0, id, o);
            chk($sformatf("vec%0d_id", i), id, vecs[i].port);
            chk($sformatf("vec%0d_o", i), o, vecs[i].exp_o);
        end

        // Test 2: both held valid, round-robin alternation (prio is 0 after vec13 on port 1)
        drive(0, 1'b1, 1, 2, 0);
        drive(1, 1'b1, 4, -2, 1);
        rsp_ready = 1'b1;
        #1;
        nr = 0;
        for (int c = 0; c < 60 && nr < 4; c++) begin
            if (req0_ready) g.push_back(0);
            if (req1_ready) g.push_back(1);
            if (req0_ready && req1_ready) chk("t2_both_ready", 1, 0);
            if (rsp_valid) begin
                rid.push_back(rsp_id);
                ro.push_back(rsp_o);
                nr++;
            end
            tick();
        end
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        chk("t2_rsp_count", nr, 4);
        chk("t2_grant_count", g.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < g.size()) chk($sformatf("t2_grant%0d", i), g[i], i % 2);
            if (i < rid.size()) begin
                chk($sformatf("t2_rsp_id%0d", i), rid[i], i % 2);
                chk($sformatf("t2_rsp_o%0d", i), ro[i], (i % 2 == 0) ? 3 : 6);
            end
        end

        // Test 3: back-pressure holds the response and blocks the other requester
        rsp_ready = 1'b0;
        drive(0, 1'b1, 2, 3, 0);
        #1;
        chk("t3_req0_ready", req0_ready, 1);
        tick();
        drive(0, 1'b0, 0, 0, 0);
        tick();
        drive(1, 1'b1, 1, 1, 0);
        cnt0 = op_count;
        for (int c = 0; c < 5; c++) begin
            chk("t3_hold_valid", rsp_valid, 1);
            chk("t3_hold_o", rsp_o, 5);
            chk("t3_hold_id", rsp_id, 0);
            chk("t3_hold_busy", busy, 1);
            chk("t3_req1_blocked", req1_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("t3_count_inc", op_count, (cnt0 + 1) % 65536);
        chk("t3_rsp_dropped", rsp_valid, 0);
        chk("t3_req1_granted", req1_ready, 1);
        tick();
        drive(1, 1'b0, 0, 0, 0);
        tick();
        chk("t3_req1_o", rsp_o, 2);
        chk("t3_req1_id", rsp_id, 1);
        tick();
        chk("t3_count_once_more", op_count, (cnt0 + 2) % 65536);

        // Test 4: operands change after acceptance
        run_op(1, -8, 7, 7, 1'b0, id, o);
        chk("t4_id", id, 1);
        chk("t4_o", o, -32);

        // Test 5a: reset during EXEC (req0 granted, so prio would point at req1)
        drive(0, 1'b1, 1, 1, 0);
        #1;
        tick();
        drive(1, 1'b1, 2, 2, 0);
        reset = 1'b1;
        #1;
        chk("t5a_ready0_in_reset", req0_ready, 0);
        chk("t5a_ready1_in_reset", req1_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("t5a_rsp_valid", rsp_valid, 0);
        chk("t5a_busy", busy, 0);
        chk("t5a_op_count", op_count, 0);
        chk("t5a_grant0", req0_ready, 1);
        chk("t5a_nogrant1", req1_ready, 0);
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        tick();

        // Test 5b: reset during RESP
        run_op(1, 1, 1, 0, 1'b0, id, o);
        rsp_ready = 1'b0;
        drive(0, 1'b1, 3, 3, 0);
        #1;
        tick();
        drive(0, 1'b0, 0, 0, 0);
        tick();
        chk("t5b_in_resp", rsp_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rsp_ready = 1'b1;
        drive(0, 1'b1, 1, 1, 0);
        drive(1, 1'b1, 2, 2, 0);
        #1;
        chk("t5b_rsp_valid", rsp_valid, 0);
        chk("t5b_busy", busy, 0);
        chk("t5b_op_count", op_count, 0);
        chk("t5b_grant0", req0_ready, 1);
        chk("t5b_nogrant1", req1_ready, 0);
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        tick();
        chk("t5b_no_late_rsp", rsp_valid, 0);

        // Test 6: exhaustive sweep on both ports with random back-pressure
        base = op_count;
        nreq = 0;
        for (int s = 0; s < 8; s++) begin
            for (int x = -8; x < 8; x++) begin
                for (int y = -8; y < 8; y++) begin
                    for (int p = 0; p < 2; p++) begin
                        run_op(p, x, y, s, 1'b1, id, o);
                        nreq++;
                        chk($sformatf("sweep_id p%0d", p), id, p);
                        chk($sformatf("sweep_o s%0d x%0d y%0d", s, x, y), o, gold(x, y, s));
                    end
                end
            end
        end
        chk("sweep_rsp_count", op_count, (base + nreq) % 65536);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
